// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use / branch hazard control and EX operand forwarding
//
// Purpose: stalls the front end for one cycle on a load-use hazard, flushes
// IF/ID and redirects the PC on a taken branch (then holds FLUSH for FLUSH_LEN
// cycles), and selects the EX ALU operand sources from MEM/WB.
//
// Optional feature: define HAZARD_PERF_CNT_EN to build the saturating
// stall/flush performance counters; otherwise stall_cnt/flush_cnt are 0.
//
// Parameters:
//   CNT_W      width of the performance counters
//   FLUSH_LEN  cycles spent in FLUSH after a taken branch (1..3)
//
// Ports:
//   clk, rst_n                                  clock, async active-low reset
//   id_rs1_addr, id_rs2_addr, id_rs2_en         ID source registers
//   ex_rs1_addr, ex_rs2_addr, ex_rd_addr        EX register addresses
//   ex_reg_wr_en, ex_mem_rd_en                  EX writeback / load flags
//   ex_br_en, ex_br_taken                       EX branch resolution
//   mem_rd_addr, mem_reg_wr_en, mem_mem_rd_en   MEM writeback info
//   wb_rd_addr, wb_reg_wr_en                    WB writeback info
//   pc_stall, ifid_stall, idex_bubble           load-use stall controls
//   ifid_flush, pc_redirect                     taken-branch controls
//   fwd_a_sel, fwd_b_sel                        00 rf, 01 MEM alu, 10 WB, 11 MEM load
//   stall_cnt, flush_cnt                        performance counters

module pipe_hazard_ctrl #(
    parameter int CNT_W     = 32,
    parameter int FLUSH_LEN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_rs2_en,
    input  logic [4:0]       ex_rs1_addr,
    input  logic [4:0]       ex_rs2_addr,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_reg_wr_en,
    input  logic             ex_mem_rd_en,
    input  logic             ex_br_en,
    input  logic             ex_br_taken,
    input  logic [4:0]       mem_rd_addr,
    input  logic             mem_reg_wr_en,
    input  logic             mem_mem_rd_en,
    input  logic [4:0]       wb_rd_addr,
    input  logic             wb_reg_wr_en,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             pc_redirect,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_LEN);

    state_t     state, state_next;
    logic [1:0] flush_left, flush_left_next;

    logic load_use;
    logic br_taken;
    logic stall_c, bubble_c, flush_c;

    assign load_use = ex_mem_rd_en & ex_reg_wr_en & (ex_rd_addr != 5'd0) &
                      ((ex_rd_addr == id_rs1_addr) |
                       (id_rs2_en & (ex_rd_addr == id_rs2_addr)));
    assign br_taken = ex_br_en & ex_br_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            flush_left <= 2'd0;
        end else begin
            state      <= state_next;
            flush_left <= flush_left_next;
        end
    end

    // LSTALL reacts to hazards exactly like RUN; it only exists so that the
    // stall is a single cycle (the stalled instruction re-evaluates next cycle).
    always_comb begin
        state_next      = state;
        flush_left_next = flush_left;
        stall_c         = 1'b0;
        bubble_c        = 1'b0;
        flush_c         = 1'b0;
        case (state)
            RUN, LSTALL: begin
                if (br_taken) begin
                    flush_c         = 1'b1;
                    bubble_c        = 1'b1;
                    state_next      = FLUSH;
                    flush_left_next = FLUSH_LOAD;
                end else if (load_use) begin
                    stall_c    = 1'b1;
                    bubble_c   = 1'b1;
                    state_next = LSTALL;
                end else begin
                    state_next = RUN;
                end
            end
            FLUSH: begin
                // EX carries a bubble here, so its branch/load bits are ignored.
                if (flush_left <= 2'd1) begin
                    state_next      = RUN;
                    flush_left_next = 2'd0;
                end else begin
                    flush_left_next = flush_left - 2'd1;
                end
            end
            default: begin
                state_next      = RUN;
                flush_left_next = 2'd0;
            end
        endcase
    end

    // Outputs are gated by rst_n so they drop immediately when reset asserts.
    assign pc_stall    = rst_n & stall_c;
    assign ifid_stall  = rst_n & stall_c;
    assign idex_bubble = rst_n & bubble_c;
    assign ifid_flush  = rst_n & flush_c;
    assign pc_redirect = rst_n & flush_c;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (rs == 5'd0)
            fwd_sel = 2'b00;
        else if (mem_reg_wr_en & mem_mem_rd_en & (mem_rd_addr == rs))
            fwd_sel = 2'b11;
        else if (mem_reg_wr_en & (mem_rd_addr == rs))
            fwd_sel = 2'b01;
        else if (wb_reg_wr_en & (wb_rd_addr == rs))
            fwd_sel = 2'b10;
        else
            fwd_sel = 2'b00;
    endfunction

    assign fwd_a_sel = rst_n ? fwd_sel(ex_rs1_addr) : 2'b00;
    assign fwd_b_sel = rst_n ? fwd_sel(ex_rs2_addr) : 2'b00;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_c && !(&stall_q))
                stall_q <= stall_q + 1'b1;
            if (flush_c && !(&flush_q))
                flush_q <= flush_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl

module tb_pipe_hazard_ctrl;

    localparam int FL = 2;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    id_rs1_addr, id_rs2_addr;
    logic          id_rs2_en;
    logic [4:0]    ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
    logic          ex_reg_wr_en, ex_mem_rd_en, ex_br_en, ex_br_taken;
    logic [4:0]    mem_rd_addr;
    logic          mem_reg_wr_en, mem_mem_rd_en;
    logic [4:0]    wb_rd_addr;
    logic          wb_reg_wr_en;
    logic          pc_stall, ifid_stall, idex_bubble, ifid_flush, pc_redirect;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic [CW-1:0] stall_cnt, flush_cnt;

    pipe_hazard_ctrl #(.CNT_W(CW), .FLUSH_LEN(FL)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rs2_en(id_rs2_en),
        .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
        .ex_reg_wr_en(ex_reg_wr_en), .ex_mem_rd_en(ex_mem_rd_en),
        .ex_br_en(ex_br_en), .ex_br_taken(ex_br_taken),
        .mem_rd_addr(mem_rd_addr), .mem_reg_wr_en(mem_reg_wr_en), .mem_mem_rd_en(mem_mem_rd_en),
        .wb_rd_addr(wb_rd_addr), .wb_reg_wr_en(wb_reg_wr_en),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_bubble(idex_bubble),
        .ifid_flush(ifid_flush), .pc_redirect(pc_redirect),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: cycles of FLUSH still owed, and event counts.
    int m_flush_left = 0;
    int m_stalls     = 0;
    int m_flushes    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int exp_cnt(input int n);
`ifdef HAZARD_PERF_CNT_EN
        return (n > CNT_MAX) ? CNT_MAX : n;
`else
        return 0;
`endif
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (rs == 0) return 2'b00;
        if (mem_reg_wr_en && mem_mem_rd_en && mem_rd_addr == rs) return 2'b11;
        if (mem_reg_wr_en && mem_rd_addr == rs) return 2'b01;
        if (wb_reg_wr_en && wb_rd_addr == rs) return 2'b10;
        return 2'b00;
    endfunction

    task automatic clear_in();
        {id_rs1_addr, id_rs2_addr, ex_rs1_addr, ex_rs2_addr, ex_rd_addr} = '0;
        {mem_rd_addr, wb_rd_addr} = '0;
        {id_rs2_en, ex_reg_wr_en, ex_mem_rd_en, ex_br_en, ex_br_taken} = '0;
        {mem_reg_wr_en, mem_mem_rd_en, wb_reg_wr_en} = '0;
    endtask

    task automatic rand_in();
        id_rs1_addr   = 5'($urandom_range(0, 3));
        id_rs2_addr   = 5'($urandom_range(0, 3));
        id_rs2_en     = 1'($urandom_range(0, 1));
        ex_rs1_addr   = 5'($urandom_range(0, 3));
        ex_rs2_addr   = 5'($urandom_range(0, 3));
        ex_rd_addr    = 5'($urandom_range(0, 3));
        ex_reg_wr_en  = 1'($urandom_range(0, 1));
        ex_mem_rd_en  = 1'($urandom_range(0, 1));
        ex_br_en      = ($urandom_range(0, 3) == 0);
        ex_br_taken   = 1'($urandom_range(0, 1));
        mem_rd_addr   = 5'($urandom_range(0, 3));
        mem_reg_wr_en = 1'($urandom_range(0, 1));
        mem_mem_rd_en = 1'($urandom_range(0, 1));
        wb_rd_addr    = 5'($urandom_range(0, 3));
        wb_reg_wr_en  = 1'($urandom_range(0, 1));
    endtask

    // Called at a falling edge with inputs applied; checks this cycle, then
    // advances the model over the coming rising edge.
    task automatic step();
        logic lu, br, e_stall, e_bub, e_flush;
        #1;
        lu = ex_mem_rd_en && ex_reg_wr_en && ex_rd_addr != 0 &&
             (ex_rd_addr == id_rs1_addr || (id_rs2_en && ex_rd_addr == id_rs2_addr));
        br = ex_br_en && ex_br_taken;
        e_stall = 0; e_bub = 0; e_flush = 0;
        if (m_flush_left == 0) begin
            if (br) begin
                e_flush = 1; e_bub = 1;
            end else if (lu) begin
                e_stall = 1; e_bub = 1;
            end
        end
        chk("pc_stall",    32'(pc_stall),    32'(e_stall));
        chk("ifid_stall",  32'(ifid_stall),  32'(e_stall));
        chk("idex_bubble", 32'(idex_bubble), 32'(e_bub));
        chk("ifid_flush",  32'(ifid_flush),  32'(e_flush));
        chk("pc_redirect", 32'(pc_redirect), 32'(e_flush));
        chk("fwd_a_sel",   32'(fwd_a_sel),   32'(ref_fwd(ex_rs1_addr)));
        chk("fwd_b_sel",   32'(fwd_b_sel),   32'(ref_fwd(ex_rs2_addr)));
        chk("stall_cnt",   32'(stall_cnt),   32'(exp_cnt(m_stalls)));
        chk("flush_cnt",   32'(flush_cnt),   32'(exp_cnt(m_flushes)));
        if (m_flush_left > 0)
            m_flush_left--;
        else if (br) begin
            m_flush_left = FL;
            m_flushes++;
        end else if (lu)
            m_stalls++;
        @(negedge clk);
    endtask

    // Asynchronous reset pulse between clock edges with hazards on the inputs.
    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        ex_br_en = 1; ex_br_taken = 1;
        ex_mem_rd_en = 1; ex_reg_wr_en = 1; ex_rd_addr = 5'd7; id_rs1_addr = 5'd7;
        mem_reg_wr_en = 1; mem_rd_addr = 5'd7; ex_rs1_addr = 5'd7; ex_rs2_addr = 5'd7;
        #1;
        chk("rst_pc_redirect", 32'(pc_redirect), 32'd0);
        chk("rst_pc_stall",    32'(pc_stall),    32'd0);
        chk("rst_idex_bubble", 32'(idex_bubble), 32'd0);
        chk("rst_fwd_a",       32'(fwd_a_sel),   32'd0);
        chk("rst_stall_cnt",   32'(stall_cnt),   32'd0);
        chk("rst_flush_cnt",   32'(flush_cnt),   32'd0);
        m_flush_left = 0; m_stalls = 0; m_flushes = 0;
        @(negedge clk);
        rst_n = 1'b1;
        clear_in();
    endtask

    initial begin
        clear_in();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_pc_stall",  32'(pc_stall),  32'd0);
        chk("reset_flush_cnt", 32'(flush_cnt), 32'd0);
        rst_n = 1'b1;

        // Load-use on rs1=x5, then the load sits in MEM: one stall cycle, then 11.
        clear_in();
        ex_mem_rd_en = 1; ex_reg_wr_en = 1; ex_rd_addr = 5'd5; id_rs1_addr = 5'd5;
        #1 chk("lu_stall", 32'(pc_stall), 32'd1);
        step();
        clear_in();
        mem_rd_addr = 5'd5; mem_reg_wr_en = 1; mem_mem_rd_en = 1; ex_rs1_addr = 5'd5;
        #1 chk("lu_fwd_load", 32'(fwd_a_sel), 32'd3);
        chk("lu_released", 32'(pc_stall), 32'd0);
        step();

        // Back-to-back load-use: second one honoured from LSTALL.
        clear_in();
        ex_mem_rd_en = 1; ex_reg_wr_en = 1; ex_rd_addr = 5'd9; id_rs2_addr = 5'd9; id_rs2_en = 1;
        step();
        ex_rd_addr = 5'd10; id_rs1_addr = 5'd10;
        step();
        clear_in();
        step();

        // Forwarding priority on x3.
        clear_in();
        ex_rs1_addr = 5'd3; mem_rd_addr = 5'd3; mem_reg_wr_en = 1; wb_rd_addr = 5'd3; wb_reg_wr_en = 1;
        #1 chk("fwd_mem", 32'(fwd_a_sel), 32'd1);
        mem_reg_wr_en = 0;
        #1 chk("fwd_wb", 32'(fwd_a_sel), 32'd2);
        ex_rs1_addr = 5'd0; mem_rd_addr = 5'd0; wb_rd_addr = 5'd0; mem_reg_wr_en = 1;
        #1 chk("fwd_x0", 32'(fwd_a_sel), 32'd0);
        step();

        // Branch + load-use together, then branches ignored in FLUSH.
        clear_in();
        ex_br_en = 1; ex_br_taken = 1;
        ex_mem_rd_en = 1; ex_reg_wr_en = 1; ex_rd_addr = 5'd4; id_rs1_addr = 5'd4;
        #1 chk("br_lu_redirect", 32'(pc_redirect), 32'd1);
        chk("br_lu_no_stall", 32'(pc_stall), 32'd0);
        step();
        #1 chk("flush_ignored1", 32'(pc_redirect), 32'd0);
        step();
        #1 chk("flush_ignored2", 32'(pc_redirect), 32'd0);
        step();
        #1 chk("run_again", 32'(pc_redirect), 32'd1);
        step();

        // Reset asserted during FLUSH, then a branch is taken right after release.
        step();
        pulse_reset();
        ex_br_en = 1; ex_br_taken = 1;
        #1 chk("post_rst_redirect", 32'(pc_redirect), 32'd1);
        step();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            rand_in();
            if ($urandom_range(0, 79) == 0)
                pulse_reset();
            else
                step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
